verificar_pin: RTL and testbench
================================

Name: verificar_pin

Overview:
- Consumer end of the PIN packet interface: receives the `pinPac_t` packet built by the keypad assembler and compares it against a stored 4-digit PIN.
- Drives the lock actuator, counts failed attempts, and enforces an alarm/lockout period after too many failures.
- Sits between the keypad PIN assembler and the lock driver / display logic.

Parameters:
- DEFAULT_PIN, 16'h1234: reset value of the stored PIN; digit1 in [15:12] through digit4 in [3:0]; no nibble may equal 4'hA.
- MAX_ATTEMPTS, 3: consecutive failures that trigger lockout; must be >= 1.
- UNLOCK_CYCLES, 50_000_000: clk cycles the lock stays open after a correct PIN; must be >= 1.
- LOCKOUT_CYCLES, 250_000_000: clk cycles of alarm/lockout; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pin_in  input  pinPac_t  packet; `.status` is a 1-cycle submit pulse; `.digit1`..`.digit4` are 4-bit each, 4'hA = blank.
- unlock  output  1  lock actuator, 1 = open.
- alarm  output  1  high for the whole lockout period.
- err_pulse  output  1  1-cycle pulse on a rejected PIN that does not cause lockout.
- ok_pulse  output  1  1-cycle pulse on an accepted PIN.
- attempts  output  $clog2(MAX_ATTEMPTS+1)  current consecutive-failure count.
- locked_out  output  1  high while in LOCKOUT.

Behaviour:
- Reset: all state is synchronous on rst=1 at a clk edge; rst has priority over everything.
  - State -> IDLE; stored PIN -> DEFAULT_PIN; captured digits -> 4'hA; timer -> 0; fail count -> 0.
  - unlock=0, alarm=0, err_pulse=0, ok_pulse=0, attempts=0, locked_out=0.
  - Reset mid-OPEN or mid-LOCKOUT aborts immediately: lock closes, alarm drops.
- All outputs are registered.
- FSM states: IDLE, CHECK, OPEN, LOCKOUT.
- IDLE:
  - On pin_in.status=1 at edge N: latch the four digits and go to CHECK.
  - status=0: stay.
- CHECK: exactly one cycle; status is ignored.
  - Match means every captured digit != 4'hA and all four equal the stored PIN.
  - On match, at edge N+1: go to OPEN, unlock<=1, ok_pulse<=1, fail count<=0, timer<=UNLOCK_CYCLES-1.
  - On mismatch with fail+1 < MAX_ATTEMPTS: fail<=fail+1, err_pulse<=1, return to IDLE.
  - On mismatch with fail+1 == MAX_ATTEMPTS: go to LOCKOUT, alarm<=1, locked_out<=1, fail<=MAX_ATTEMPTS, timer<=LOCKOUT_CYCLES-1; err_pulse stays 0.
- Latency: submit pulse at edge N -> unlock / err_pulse / alarm visible after edge N+1, i.e. 2 cycles after status is asserted.
- OPEN:
  - Timer decrements each cycle.
  - When timer==0: go to IDLE and set unlock<=0. unlock is high for exactly UNLOCK_CYCLES cycles.
  - status pulses are ignored, except as described under Optional Feature.
- LOCKOUT:
  - All status pulses are ignored; timer decrements each cycle.
  - When timer==0: go to IDLE, alarm<=0, locked_out<=0, fail<=0.
  - alarm is high for exactly LOCKOUT_CYCLES cycles.
- Fail count resets only on an accepted PIN, on lockout expiry, or on rst; it never wraps.
- Blank rule: an incomplete PIN (fewer than 4 digits typed) contains 4'hA and always counts as a failure. The keypad key A is therefore never a valid PIN digit.
- Back-to-back status pulses (any spacing, including consecutive cycles): a pulse arriving while not in IDLE is dropped, never queued.

Optional Feature:
- Macro: PIN_CHANGE_EN.
- Defined:
  - In OPEN, a status pulse whose four digits are all != 4'hA replaces the stored PIN at the next edge.
  - The same edge pulses ok_pulse for 1 cycle, sets unlock<=0 and goes to IDLE (relock).
  - A pulse containing any blank digit in OPEN is ignored; the timer continues.
- Not defined: the stored PIN is constant at DEFAULT_PIN after reset, and all status pulses in OPEN are ignored.

Test Plan (params DEFAULT_PIN=16'h1234, MAX_ATTEMPTS=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16):
- Submit 1,2,3,4 -> 2 cycles later ok_pulse=1 for 1 cycle; unlock=1 for exactly 8 cycles, then 0; attempts=0.
- Submit 1,2,3,5, then A,1,2,3 (blank) -> err_pulse each time; attempts=1 then 2; unlock stays 0.
- Three wrong PINs (9,9,9,9) -> attempts 1,2,3; the third sets alarm=locked_out=1 for 16 cycles with no err_pulse. Submitting 1,2,3,4 during lockout has no effect. After expiry attempts=0, and 1,2,3,4 then unlocks.
- Two wrong PINs then 1,2,3,4 -> unlock, attempts=0; a further two wrong PINs give attempts=2 with no alarm.
- Assert rst during OPEN (cycle 3) and during LOCKOUT -> next edge unlock=0, alarm=0, attempts=0, state IDLE; 1,2,3,4 then unlocks normally.
- PIN_CHANGE_EN: unlock with 1,2,3,4; submit 5,6,7,8 while open -> ok_pulse, unlock=0. Then 1,2,3,4 is rejected and 5,6,7,8 is accepted. Without the macro, 1,2,3,4 is still accepted after the same sequence.

Source files
------------

// File: rtl/verificar_pin_if.sv
// -----------------------------------------------------------------------------
// verificar_pin_if
//   PIN packet bus between the keypad PIN assembler (producer) and the PIN
//   checker (consumer).
//
//   pac.status  : 1-cycle submit pulse
//   pac.digit1  : first typed digit  (4'hA = blank)
//   pac.digit2  : second typed digit (4'hA = blank)
//   pac.digit3  : third typed digit  (4'hA = blank)
//   pac.digit4  : fourth typed digit (4'hA = blank)
//
//   Modports: master (keypad assembler drives pac), slave (checker reads pac).
// -----------------------------------------------------------------------------
interface verificar_pin_if;

    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

    pinPac_t pac;

    modport master (output pac);
    modport slave  (input  pac);

endinterface

// File: rtl/verificar_pin.sv
// -----------------------------------------------------------------------------
// verificar_pin
//   Consumer end of the PIN packet interface. Compares a submitted 4-digit PIN
//   against the stored PIN, drives the lock actuator, counts consecutive
//   failures and holds an alarm/lockout period after MAX_ATTEMPTS failures.
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   synchronous active-high reset, highest priority
//     pin_in     in   verificar_pin_if.slave, PIN packet (status + 4 digits)
//     unlock     out  lock actuator, 1 = open
//     alarm      out  high for the whole lockout period
//     err_pulse  out  1-cycle pulse on a rejected PIN that does not lock out
//     ok_pulse   out  1-cycle pulse on an accepted PIN (or a PIN change)
//     attempts   out  current consecutive-failure count
//     locked_out out  high while in LOCKOUT
//
//   Optional feature macro: PIN_CHANGE_EN
//     When defined, a fully typed PIN submitted while the lock is open
//     replaces the stored PIN and relocks. When undefined the stored PIN is
//     fixed at DEFAULT_PIN and submissions during OPEN are ignored.
//
//   All outputs are registered. Submit at edge N -> result visible after N+1.
// -----------------------------------------------------------------------------
module verificar_pin #(
    parameter logic [15:0] DEFAULT_PIN    = 16'h1234,
    parameter int          MAX_ATTEMPTS   = 3,
    parameter int          UNLOCK_CYCLES  = 50_000_000,
    parameter int          LOCKOUT_CYCLES = 250_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    verificar_pin_if.slave                    pin_in,
    output logic                              unlock,
    output logic                              alarm,
    output logic                              err_pulse,
    output logic                              ok_pulse,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts,
    output logic                              locked_out
);

    localparam logic [3:0]  BLANK   = 4'hA;
    localparam int          FAIL_W  = $clog2(MAX_ATTEMPTS + 1);
    localparam int          T_MAX   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                       : LOCKOUT_CYCLES;
    // The timer only ever holds values up to T_MAX-1.
    localparam int          TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO   = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_ONE    = {{(TIMER_W-1){1'b0}}, 1'b1};
    localparam logic [FAIL_W-1:0]  FAIL_ZERO    = {FAIL_W{1'b0}};
    localparam logic [FAIL_W-1:0]  FAIL_MAX     = FAIL_W'(MAX_ATTEMPTS);
    localparam logic [FAIL_W:0]    FAIL_LIMIT   = (FAIL_W+1)'(MAX_ATTEMPTS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CHECK   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    // True when any nibble of a packed 4-digit code is the blank marker.
    function automatic logic has_blank(input logic [15:0] code);
        has_blank = (code[15:12] == BLANK) || (code[11:8] == BLANK) ||
                    (code[7:4]   == BLANK) || (code[3:0]  == BLANK);
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [15:0]         code_r;
    logic [15:0]         code_nxt_s;
    logic [15:0]         pin_r;
    logic [15:0]         pin_nxt_s;
    logic [TIMER_W-1:0]  timer_r;
    logic [TIMER_W-1:0]  timer_nxt_s;
    logic [FAIL_W-1:0]   fail_r;
    logic [FAIL_W-1:0]   fail_nxt_s;
    logic                unlock_r;
    logic                unlock_nxt_s;
    logic                alarm_r;
    logic                alarm_nxt_s;
    logic                err_r;
    logic                err_nxt_s;
    logic                ok_r;
    logic                ok_nxt_s;
    logic                lock_r;
    logic                lock_nxt_s;

    logic                status_s;
    logic [15:0]         in_code_s;
    logic                match_s;
    logic [FAIL_W:0]     fail_inc_s;
    logic                last_try_s;
    logic                change_s;
    logic                timer_done_s;

    assign status_s  = pin_in.pac.status;
    assign in_code_s = {pin_in.pac.digit1, pin_in.pac.digit2,
                        pin_in.pac.digit3, pin_in.pac.digit4};

    // A blank digit can never match, even if the stored PIN were corrupted.
    assign match_s      = !has_blank(code_r) && (code_r == pin_r);
    // One bit wider so fail+1 cannot wrap before the comparison.
    assign fail_inc_s   = {1'b0, fail_r} + {{FAIL_W{1'b0}}, 1'b1};
    assign last_try_s   = (fail_inc_s == FAIL_LIMIT);
    assign timer_done_s = (timer_r == TIMER_ZERO);

`ifdef PIN_CHANGE_EN
    assign change_s = status_s && !has_blank(in_code_s);
`else
    assign change_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; submissions outside IDLE are dropped, never queued.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (status_s) begin
                    state_nxt_s = S_CHECK;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CHECK: begin
                if (match_s) begin
                    state_nxt_s = S_OPEN;
                end else if (last_try_s) begin
                    state_nxt_s = S_LOCKOUT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_OPEN: begin
                if (change_s || timer_done_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_OPEN;
                end
            end
            S_LOCKOUT: begin
                if (timer_done_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_LOCKOUT;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; levels hold, pulses default low.
    always_comb begin
        code_nxt_s   = code_r;
        pin_nxt_s    = pin_r;
        timer_nxt_s  = timer_r;
        fail_nxt_s   = fail_r;
        unlock_nxt_s = unlock_r;
        alarm_nxt_s  = alarm_r;
        lock_nxt_s   = lock_r;
        err_nxt_s    = 1'b0;
        ok_nxt_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (status_s) begin
                    code_nxt_s = in_code_s;
                end else begin
                    code_nxt_s = code_r;
                end
            end
            S_CHECK: begin
                if (match_s) begin
                    unlock_nxt_s = 1'b1;
                    ok_nxt_s     = 1'b1;
                    fail_nxt_s   = FAIL_ZERO;
                    timer_nxt_s  = UNLOCK_LOAD;
                end else if (last_try_s) begin
                    // Lockout replaces the error pulse.
                    alarm_nxt_s  = 1'b1;
                    lock_nxt_s   = 1'b1;
                    fail_nxt_s   = FAIL_MAX;
                    timer_nxt_s  = LOCKOUT_LOAD;
                end else begin
                    fail_nxt_s   = fail_inc_s[FAIL_W-1:0];
                    err_nxt_s    = 1'b1;
                end
            end
            S_OPEN: begin
                if (change_s) begin
                    // New PIN accepted while open: store it and relock.
                    pin_nxt_s    = in_code_s;
                    ok_nxt_s     = 1'b1;
                    unlock_nxt_s = 1'b0;
                    timer_nxt_s  = TIMER_ZERO;
                end else if (timer_done_s) begin
                    unlock_nxt_s = 1'b0;
                end else begin
                    timer_nxt_s  = timer_r - TIMER_ONE;
                end
            end
            S_LOCKOUT: begin
                if (timer_done_s) begin
                    alarm_nxt_s  = 1'b0;
                    lock_nxt_s   = 1'b0;
                    fail_nxt_s   = FAIL_ZERO;
                end else begin
                    timer_nxt_s  = timer_r - TIMER_ONE;
                end
            end
            default: begin
                // Unreachable encoding: force everything to a safe, closed state.
                unlock_nxt_s = 1'b0;
                alarm_nxt_s  = 1'b0;
                lock_nxt_s   = 1'b0;
                timer_nxt_s  = TIMER_ZERO;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_r   <= {BLANK, BLANK, BLANK, BLANK};
            pin_r    <= DEFAULT_PIN;
            timer_r  <= TIMER_ZERO;
            fail_r   <= FAIL_ZERO;
            unlock_r <= 1'b0;
            alarm_r  <= 1'b0;
            lock_r   <= 1'b0;
            err_r    <= 1'b0;
            ok_r     <= 1'b0;
        end else begin
            code_r   <= code_nxt_s;
            pin_r    <= pin_nxt_s;
            timer_r  <= timer_nxt_s;
            fail_r   <= fail_nxt_s;
            unlock_r <= unlock_nxt_s;
            alarm_r  <= alarm_nxt_s;
            lock_r   <= lock_nxt_s;
            err_r    <= err_nxt_s;
            ok_r     <= ok_nxt_s;
        end
    end

    assign unlock     = unlock_r;
    assign alarm      = alarm_r;
    assign err_pulse  = err_r;
    assign ok_pulse   = ok_r;
    assign attempts   = fail_r;
    assign locked_out = lock_r;

endmodule

// File: tb/tb_verificar_pin.sv
// -----------------------------------------------------------------------------
// tb_verificar_pin
//   Directed self-checking bench for verificar_pin with DEFAULT_PIN=16'h1234,
//   MAX_ATTEMPTS=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16. Inputs are driven and
//   outputs sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_verificar_pin;

    logic       clk;
    logic       rst;
    logic       unlock;
    logic       alarm;
    logic       err_pulse;
    logic       ok_pulse;
    logic [1:0] attempts;
    logic       locked_out;

    int total;
    int bad;

    verificar_pin_if bus ();

    verificar_pin #(
        .DEFAULT_PIN    (16'h1234),
        .MAX_ATTEMPTS   (3),
        .UNLOCK_CYCLES  (8),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pin_in     (bus),
        .unlock     (unlock),
        .alarm      (alarm),
        .err_pulse  (err_pulse),
        .ok_pulse   (ok_pulse),
        .attempts   (attempts),
        .locked_out (locked_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input logic [15:0] code);
        bus.pac.digit1 = code[15:12];
        bus.pac.digit2 = code[11:8];
        bus.pac.digit3 = code[7:4];
        bus.pac.digit4 = code[3:0];
    endtask

    // Present a 1-cycle submit pulse; returns 1 unit after the capturing edge.
    task automatic submit(input logic [15:0] code);
        set_code(code);
        bus.pac.status = 1'b1;
        step;
        bus.pac.status = 1'b0;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset;
        total++;
        if ({unlock, alarm, err_pulse, ok_pulse, attempts, locked_out} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0000000",
                     {unlock, alarm, err_pulse, ok_pulse, attempts, locked_out});
        end
    endtask

    task automatic test_unlock;
        int cnt;
        apply_reset;
        submit(16'h1234);
        step;
        total++;
        if ({ok_pulse, unlock, err_pulse} !== 3'b110) begin
            bad++;
            $display("FAIL unlock_accept ok/unlock/err got=%b want=110", {ok_pulse, unlock, err_pulse});
        end
        total++;
        if (attempts !== 2'd0) begin
            bad++;
            $display("FAIL unlock_attempts got=%0d want=0", attempts);
        end
        step;
        total++;
        if (ok_pulse !== 1'b0) begin
            bad++;
            $display("FAIL unlock_ok_width got=%b want=0", ok_pulse);
        end
        cnt = 2;
        for (int i = 0; i < 30 && unlock === 1'b1; i++) begin
            step;
            if (unlock === 1'b1) cnt++;
        end
        total++;
        if (cnt !== 8 || unlock !== 1'b0) begin
            bad++;
            $display("FAIL unlock_duration got=%0d want=8", cnt);
        end
    endtask

    task automatic test_errors;
        apply_reset;
        submit(16'h1235);
        step;
        total++;
        if ({err_pulse, unlock, attempts} !== 4'b1001) begin
            bad++;
            $display("FAIL err_wrong err/unlock/att got=%b want=1001", {err_pulse, unlock, attempts});
        end
        step;
        total++;
        if (err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse_width got=%b want=0", err_pulse);
        end
        submit(16'hA123);
        step;
        total++;
        if ({err_pulse, unlock, attempts} !== 4'b1010) begin
            bad++;
            $display("FAIL err_blank err/unlock/att got=%b want=1010", {err_pulse, unlock, attempts});
        end
    endtask

    task automatic test_lockout;
        int  cnt;
        logic saw_unlock;
        apply_reset;
        submit(16'h9999);
        step;
        total++;
        if ({err_pulse, attempts} !== 3'b101) begin
            bad++;
            $display("FAIL lock_try1 err/att got=%b want=101", {err_pulse, attempts});
        end
        submit(16'h9999);
        step;
        total++;
        if ({err_pulse, attempts, alarm} !== 4'b1100) begin
            bad++;
            $display("FAIL lock_try2 err/att/alarm got=%b want=1100", {err_pulse, attempts, alarm});
        end
        submit(16'h9999);
        step;
        total++;
        if ({alarm, locked_out, err_pulse, attempts} !== 5'b11011) begin
            bad++;
            $display("FAIL lock_enter alarm/lo/err/att got=%b want=11011",
                     {alarm, locked_out, err_pulse, attempts});
        end
        // Count alarm cycles while a correct PIN is attempted mid-lockout.
        cnt = 1;
        saw_unlock = 1'b0;
        for (int i = 0; i < 40 && alarm === 1'b1; i++) begin
            if (cnt == 2) begin
                set_code(16'h1234);
                bus.pac.status = 1'b1;
            end else begin
                bus.pac.status = 1'b0;
            end
            step;
            if (unlock === 1'b1 || ok_pulse === 1'b1) saw_unlock = 1'b1;
            if (alarm === 1'b1) cnt++;
        end
        bus.pac.status = 1'b0;
        total++;
        if (cnt !== 16) begin
            bad++;
            $display("FAIL lock_duration got=%0d want=16", cnt);
        end
        total++;
        if (saw_unlock !== 1'b0) begin
            bad++;
            $display("FAIL lock_ignores_pin got=%b want=0", saw_unlock);
        end
        total++;
        if ({locked_out, attempts} !== 3'b000) begin
            bad++;
            $display("FAIL lock_expiry lo/att got=%b want=000", {locked_out, attempts});
        end
        submit(16'h1234);
        step;
        total++;
        if ({unlock, ok_pulse} !== 2'b11) begin
            bad++;
            $display("FAIL lock_after_unlock unlock/ok got=%b want=11", {unlock, ok_pulse});
        end
    endtask

    task automatic test_fail_clear;
        apply_reset;
        submit(16'h9999);
        step;
        submit(16'h9999);
        step;
        submit(16'h1234);
        step;
        total++;
        if ({unlock, attempts} !== 3'b100) begin
            bad++;
            $display("FAIL clear_accept unlock/att got=%b want=100", {unlock, attempts});
        end
        repeat (10) step;
        submit(16'h9999);
        step;
        submit(16'h9999);
        step;
        total++;
        if ({attempts, alarm, locked_out, err_pulse} !== 5'b10001) begin
            bad++;
            $display("FAIL clear_two_more att/alarm/lo/err got=%b want=10001",
                     {attempts, alarm, locked_out, err_pulse});
        end
    endtask

    task automatic test_reset_mid;
        apply_reset;
        submit(16'h1234);
        step;
        step;
        step;
        rst = 1'b1;
        step;
        total++;
        if ({unlock, alarm, attempts, ok_pulse} !== 5'b00000) begin
            bad++;
            $display("FAIL rst_open unlock/alarm/att/ok got=%b want=00000",
                     {unlock, alarm, attempts, ok_pulse});
        end
        rst = 1'b0;
        submit(16'h1234);
        step;
        total++;
        if (unlock !== 1'b1) begin
            bad++;
            $display("FAIL rst_open_reuse got=%b want=1", unlock);
        end
        apply_reset;
        submit(16'h9999);
        step;
        submit(16'h9999);
        step;
        submit(16'h9999);
        step;
        step;
        step;
        rst = 1'b1;
        step;
        total++;
        if ({alarm, locked_out, attempts, unlock} !== 5'b00000) begin
            bad++;
            $display("FAIL rst_lockout alarm/lo/att/unlock got=%b want=00000",
                     {alarm, locked_out, attempts, unlock});
        end
        rst = 1'b0;
        submit(16'h1234);
        step;
        total++;
        if (unlock !== 1'b1) begin
            bad++;
            $display("FAIL rst_lockout_reuse got=%b want=1", unlock);
        end
    endtask

    task automatic test_back_to_back;
        apply_reset;
        // Two consecutive submit cycles: the second lands in CHECK and is dropped.
        set_code(16'h1234);
        bus.pac.status = 1'b1;
        step;
        step;
        bus.pac.status = 1'b0;
        total++;
        if ({ok_pulse, unlock} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_accept ok/unlock got=%b want=11", {ok_pulse, unlock});
        end
        repeat (7) step;
        total++;
        if ({unlock, ok_pulse} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_still_open unlock/ok got=%b want=10", {unlock, ok_pulse});
        end
        step;
        total++;
        if (unlock !== 1'b0) begin
            bad++;
            $display("FAIL b2b_closed got=%b want=0", unlock);
        end
        // Wrong PIN immediately followed by the right one: only the first counts.
        set_code(16'h9999);
        bus.pac.status = 1'b1;
        step;
        set_code(16'h1234);
        step;
        bus.pac.status = 1'b0;
        total++;
        if ({err_pulse, attempts, unlock, ok_pulse} !== 5'b10100) begin
            bad++;
            $display("FAIL b2b_drop err/att/unlock/ok got=%b want=10100",
                     {err_pulse, attempts, unlock, ok_pulse});
        end
        step;
        total++;
        if ({unlock, ok_pulse} !== 2'b00) begin
            bad++;
            $display("FAIL b2b_no_queue unlock/ok got=%b want=00", {unlock, ok_pulse});
        end
    endtask

    task automatic test_pin_change;
        apply_reset;
        submit(16'h1234);
        step;
        submit(16'h5678);
`ifdef PIN_CHANGE_EN
        total++;
        if ({ok_pulse, unlock} !== 2'b10) begin
            bad++;
            $display("FAIL chg_relock ok/unlock got=%b want=10", {ok_pulse, unlock});
        end
`else
        total++;
        if ({ok_pulse, unlock} !== 2'b01) begin
            bad++;
            $display("FAIL chg_ignored ok/unlock got=%b want=01", {ok_pulse, unlock});
        end
`endif
        repeat (10) step;
        submit(16'h1234);
        step;
`ifdef PIN_CHANGE_EN
        total++;
        if ({err_pulse, unlock, attempts} !== 4'b1001) begin
            bad++;
            $display("FAIL chg_old_rejected err/unlock/att got=%b want=1001",
                     {err_pulse, unlock, attempts});
        end
`else
        total++;
        if ({ok_pulse, unlock} !== 2'b11) begin
            bad++;
            $display("FAIL chg_old_kept ok/unlock got=%b want=11", {ok_pulse, unlock});
        end
`endif
        repeat (10) step;
        submit(16'h5678);
        step;
`ifdef PIN_CHANGE_EN
        total++;
        if ({ok_pulse, unlock, attempts} !== 4'b1100) begin
            bad++;
            $display("FAIL chg_new_accepted ok/unlock/att got=%b want=1100",
                     {ok_pulse, unlock, attempts});
        end
`else
        total++;
        if ({err_pulse, unlock, attempts} !== 4'b1001) begin
            bad++;
            $display("FAIL chg_new_rejected err/unlock/att got=%b want=1001",
                     {err_pulse, unlock, attempts});
        end
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.pac.status = 1'b0;
        set_code(16'hAAAA);
        test_reset;
        test_unlock;
        test_errors;
        test_lockout;
        test_fail_clear;
        test_reset_mid;
        test_back_to_back;
        test_pin_change;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
